// File: rtl/c64_bus_phase.sv
// C64 bus timing master: divides clk into 1 MHz microcycles, emits phase enables
// and the CPU step strobe, and arbitrates the VIC BA/AEC handover.
module c64_bus_phase #(
  parameter int CLK_DIV    = 32,
  parameter int PH2_OFFSET = 16,
  parameter int BA_GRACE   = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ba,
  input  logic        cpu_we,
  input  logic        halt,
  output logic        clk_1mhz_ph1_en,
  output logic        clk_1mhz_ph2_en,
  output logic        rdy,
  output logic        aec,
  output logic [31:0] cycle_cnt
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BA_GRACE + 2);

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_next;
  logic [BW-1:0] ba_cnt;
  logic [BW-1:0] ba_cnt_next;
  logic          halt_q;
  logic          at_ph1;
  logic          at_ph2;
  logic          at_rdy;
  logic          step_ok;

  always_comb begin
    phase_next = (phase == PW'(CLK_DIV - 1)) ? '0 : phase + 1'b1;
    at_ph1     = (phase_next == '0);
    at_ph2     = (phase_next == PW'(PH2_OFFSET));
    at_rdy     = (phase_next == PW'(PH2_OFFSET + 1));
    // BA-low microcycles saturate one past the grace window: CPU is then locked out
    if (ba)
      ba_cnt_next = '0;
    else if (ba_cnt == BW'(BA_GRACE + 1))
      ba_cnt_next = ba_cnt;
    else
      ba_cnt_next = ba_cnt + 1'b1;
    // Inside the grace window only writes may complete; reads stall the CPU
    step_ok = !halt_q && ((ba_cnt == '0) || ((ba_cnt <= BW'(BA_GRACE)) && cpu_we));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase           <= PW'(CLK_DIV - 1);
      ba_cnt          <= '0;
      halt_q          <= 1'b0;
      clk_1mhz_ph1_en <= 1'b0;
      clk_1mhz_ph2_en <= 1'b0;
      rdy             <= 1'b0;
      aec             <= 1'b1;
      cycle_cnt       <= '0;
    end else begin
      phase           <= phase_next;
      clk_1mhz_ph1_en <= at_ph1;
      clk_1mhz_ph2_en <= at_ph2;
      rdy             <= at_rdy && step_ok;
      if (at_ph1) begin
        ba_cnt    <= ba_cnt_next;
        halt_q    <= halt;
        cycle_cnt <= cycle_cnt + 32'd1;
        aec       <= (ba_cnt_next <= BW'(BA_GRACE));
      end
    end
  end

endmodule
